// File: rtl/mul_iter_if.sv
// Handshake bundle for the iterative multiplier: operand request, result response,
// flush and busy status.
interface mul_iter_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic             in_a_signed;
    logic             in_b_signed;
    logic             in_hi;
    logic             in_word;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_res;
    logic [TAG_W-1:0] out_tag;
    logic             flush;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_a_signed, in_b_signed, in_hi, in_word, in_tag,
               out_ready, flush,
        input  in_ready, out_valid, out_res, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_a_signed, in_b_signed, in_hi, in_word, in_tag,
               out_ready, flush,
        output in_ready, out_valid, out_res, out_tag, busy
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative signed/unsigned multiplier: consumes CHUNK bits of A per cycle against the
// full B, stops early once the remaining A bits are zero, then holds the result until taken.
module mul_iter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CHUNK = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic     clk,
    input logic     rst,
    mul_iter_if.slave bus
);
    localparam int unsigned N        = XLEN / CHUNK;
    localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW       = 2 * XLEN;
    localparam int unsigned PW       = XLEN + CHUNK + 2;
    localparam int unsigned EW       = AW + 2;
    localparam bit          HAS_WORD = (XLEN == 64);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [XLEN:0]    a_ext_q, a_ext_n;
    logic [XLEN:0]    b_ext_q, b_ext_n;
    logic             hi_q, hi_n;
    logic             word_q, word_n;
    logic [TAG_W-1:0] tag_q, tag_n;
    logic [TAG_W-1:0] out_tag_q, out_tag_n;
    logic [XLEN-1:0]  out_res_q, out_res_n;
    logic [AW-1:0]    acc_q, acc_n;
    logic [CW-1:0]    cnt_q, cnt_n;

    logic             ready;
    logic             accept;
    logic [XLEN-1:0]  a_in;
    logic [XLEN-1:0]  b_in;
    logic [31:0]      sh;
    logic             last_slice;
    logic             upper_zero;
    logic             final_slice;
    logic signed [CHUNK:0] mcand;
    logic signed [PW-1:0]  prod;
    logic [EW-1:0]    prod_w;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    acc_sum;
    logic [XLEN-1:0]  res_sel;

    assign ready  = !bus.flush && (state == IDLE || (state == DONE && bus.out_ready));
    assign accept = bus.in_valid && ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_res   = out_res_q;
    assign bus.out_tag   = out_tag_q;

    // 32-bit ops narrow both operands to their low word before the usual extension
    always_comb begin : operand_ext
        a_in = bus.in_a;
        b_in = bus.in_b;
        if (HAS_WORD && bus.in_word) begin
            if (bus.in_a_signed) a_in = XLEN'($signed(bus.in_a[31:0]));
            else                 a_in = XLEN'(bus.in_a[31:0]);
            if (bus.in_b_signed) b_in = XLEN'($signed(bus.in_b[31:0]));
            else                 b_in = XLEN'(bus.in_b[31:0]);
        end
    end

    // One slice per cycle; only the top slice carries A's sign bit
    always_comb begin : slice_mul
        sh          = 32'(cnt_q) * CHUNK;
        last_slice  = (cnt_q == CW'(N - 1));
        upper_zero  = ((a_ext_q[XLEN-1:0] >> (sh + CHUNK)) == '0);
        final_slice = last_slice || upper_zero;
        if (last_slice) mcand = $signed(a_ext_q[XLEN -: CHUNK+1]);
        else            mcand = $signed({1'b0, CHUNK'(a_ext_q >> sh)});
        prod    = PW'(mcand) * PW'($signed(b_ext_q));
        prod_w  = EW'(prod);
        addend  = AW'(prod_w << sh);
        acc_sum = acc_q + addend;
    end

    always_comb begin : result_sel
        if (HAS_WORD && word_q) res_sel = XLEN'($signed(hi_q ? acc_sum[63:32] : acc_sum[31:0]));
        else                    res_sel = hi_q ? acc_sum[AW-1:XLEN] : acc_sum[XLEN-1:0];
    end

    always_comb begin : fsm_next
        state_n   = state;
        a_ext_n   = a_ext_q;
        b_ext_n   = b_ext_q;
        hi_n      = hi_q;
        word_n    = word_q;
        tag_n     = tag_q;
        acc_n     = acc_q;
        cnt_n     = cnt_q;
        out_res_n = out_res_q;
        out_tag_n = out_tag_q;

        case (state)
            BUSY: begin
                acc_n = acc_sum;
                if (final_slice) begin
                    state_n   = DONE;
                    out_res_n = res_sel;
                    out_tag_n = tag_q;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = state;
        endcase

        // Accept also covers retire-and-accept from DONE
        if (accept) begin
            state_n = BUSY;
            a_ext_n = {bus.in_a_signed & a_in[XLEN-1], a_in};
            b_ext_n = {bus.in_b_signed & b_in[XLEN-1], b_in};
            hi_n    = bus.in_hi;
            word_n  = bus.in_word;
            tag_n   = bus.in_tag;
            acc_n   = '0;
            cnt_n   = '0;
        end

        if (bus.flush) state_n = IDLE;
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state     <= IDLE;
            a_ext_q   <= '0;
            b_ext_q   <= '0;
            hi_q      <= 1'b0;
            word_q    <= 1'b0;
            tag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_res_q <= '0;
            out_tag_q <= '0;
        end else begin
            state     <= state_n;
            a_ext_q   <= a_ext_n;
            b_ext_q   <= b_ext_n;
            hi_q      <= hi_n;
            word_q    <= word_n;
            tag_q     <= tag_n;
            acc_q     <= acc_n;
            cnt_q     <= cnt_n;
            out_res_q <= out_res_n;
            out_tag_q <= out_tag_n;
        end
    end
endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: cycle-level transaction model of the 64/32 build plus a latency and
// result sweep of a 64/8 build.
module tb_mul_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_iter_if #(.XLEN(64), .TAG_W(5)) ifc ();
    mul_iter_if #(.XLEN(64), .TAG_W(5)) ifc8 ();

    mul_iter #(.XLEN(64), .CHUNK(32), .TAG_W(5)) dut  (.clk(clk), .rst(rst), .bus(ifc));
    mul_iter #(.XLEN(64), .CHUNK(8),  .TAG_W(5)) dut8 (.clk(clk), .rst(rst), .bus(ifc8));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Exact product via 128-bit arithmetic, then half / word selection
    function automatic logic [63:0] mdl_res(input logic [63:0] a, input logic [63:0] b,
                                            input logic as, input logic bs,
                                            input logic hi, input logic wd);
        logic [63:0]  aa;
        logic [63:0]  bb;
        logic [127:0] ax;
        logic [127:0] bx;
        logic [127:0] p;
        logic [31:0]  h;
        aa = a;
        bb = b;
        if (wd) begin
            if (as) aa = 64'($signed(a[31:0])); else aa = {32'h0, a[31:0]};
            if (bs) bb = 64'($signed(b[31:0])); else bb = {32'h0, b[31:0]};
        end
        if (as) ax = 128'($signed(aa)); else ax = {64'h0, aa};
        if (bs) bx = 128'($signed(bb)); else bx = {64'h0, bb};
        p = ax * bx;
        if (wd) begin
            h = hi ? p[63:32] : p[31:0];
            return 64'($signed(h));
        end
        return hi ? p[127:64] : p[63:0];
    endfunction

    // Cycles = index of the highest non-zero chunk of A (after word narrowing) plus one
    function automatic int mdl_lat(input logic [63:0] a, input logic as, input logic wd,
                                   input int chunk);
        logic [63:0] al;
        int k;
        al = a;
        k  = 1;
        if (wd) begin
            if (as) al = 64'($signed(a[31:0])); else al = {32'h0, a[31:0]};
        end
        for (int i = 1; i < 64 / chunk; i++)
            if ((al >> (i * chunk)) != 64'h0) k = i + 1;
        return k;
    endfunction

    // Transaction-level model of the 64/32 instance, advanced once per clock
    int          cyc = 0;
    bit          m_pend = 1'b0;
    int          m_done_at = 0;
    logic [63:0] m_res = '0;
    logic [4:0]  m_tag = '0;
    bit          m_acc = 1'b0;
    bit          m_prev_done;
    bit          m_exp_valid;

    always @(posedge clk) begin
        #1;
        cyc++;
        m_prev_done = m_pend && ((cyc - 1) >= m_done_at);
        m_acc = 1'b0;
        if (rst || ifc.flush) begin
            m_pend = 1'b0;
        end else begin
            m_acc = ifc.in_valid && (!m_pend || (m_prev_done && ifc.out_ready));
            if (m_acc) begin
                m_pend    = 1'b1;
                m_res     = mdl_res(ifc.in_a, ifc.in_b, ifc.in_a_signed, ifc.in_b_signed,
                                    ifc.in_hi, ifc.in_word);
                m_tag     = ifc.in_tag;
                m_done_at = cyc + mdl_lat(ifc.in_a, ifc.in_a_signed, ifc.in_word, 32);
            end else if (m_prev_done && ifc.out_ready) begin
                m_pend = 1'b0;
            end
        end
        m_exp_valid = m_pend && (cyc >= m_done_at);
        check("out_valid", 64'(ifc.out_valid), 64'(m_exp_valid));
        check("busy", 64'(ifc.busy), 64'(m_pend));
        check("in_ready", 64'(ifc.in_ready),
              64'(!ifc.flush && (!m_pend || (m_exp_valid && ifc.out_ready))));
        if (m_exp_valid) begin
            check("out_res", ifc.out_res, m_res);
            check("out_tag", 64'(ifc.out_tag), 64'(m_tag));
        end
        if (rst) begin
            check("rst_res", ifc.out_res, 64'h0);
            check("rst_tag", 64'(ifc.out_tag), 64'h0);
        end
    end

    task automatic rand_ctl();
        ifc.out_ready = ($urandom_range(0, 3) != 0);
        ifc.flush     = ($urandom_range(0, 15) == 0);
        rst           = ($urandom_range(0, 63) == 0);
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic as,
                         input logic bs, input logic hi, input logic wd,
                         input logic [4:0] tag, input bit rnd, output int waits);
        ifc.in_a = a; ifc.in_b = b; ifc.in_a_signed = as; ifc.in_b_signed = bs;
        ifc.in_hi = hi; ifc.in_word = wd; ifc.in_tag = tag; ifc.in_valid = 1'b1;
        for (int w = 1; w <= 50; w++) begin
            @(negedge clk);
            if (m_acc) begin
                ifc.in_valid = 1'b0;
                waits = w;
                return;
            end
            if (rnd) rand_ctl();
        end
        ifc.in_valid = 1'b0;
        waits = 51;
        check("accept_timeout", 64'd51, 64'd0);
    endtask

    task automatic cycles(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            if (rnd) rand_ctl();
        end
    endtask

    task automatic wait_idle();
        ifc.out_ready = 1'b1; ifc.flush = 1'b0; rst = 1'b0;
        for (int w = 0; w < 20 && m_pend; w++) @(negedge clk);
        if (m_pend) check("drain_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 4))
            0:       v = {$urandom, $urandom};
            1:       v = 64'($urandom);
            2:       v = '1;
            3:       v = 64'h0 - 64'($urandom_range(1, 1000));
            default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
        endcase
        return v;
    endfunction

    task automatic op8(input logic [63:0] a, input logic [63:0] b, input logic as,
                       input logic bs, input logic hi, input logic wd, input logic [4:0] tag);
        int lat;
        check("c8_in_ready", 64'(ifc8.in_ready), 64'd1);
        ifc8.in_a = a; ifc8.in_b = b; ifc8.in_a_signed = as; ifc8.in_b_signed = bs;
        ifc8.in_hi = hi; ifc8.in_word = wd; ifc8.in_tag = tag; ifc8.in_valid = 1'b1;
        @(negedge clk);
        ifc8.in_valid = 1'b0;
        lat = 0;
        while (!ifc8.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("c8_latency", 64'(lat), 64'(mdl_lat(a, as, wd, 8)));
        check("c8_res", ifc8.out_res, mdl_res(a, b, as, bs, hi, wd));
        check("c8_tag", 64'(ifc8.out_tag), 64'(tag));
    endtask

    initial begin
        int w;
        logic [63:0] a;
        logic [63:0] b;

        ifc.in_valid = 0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_a_signed = 0;
        ifc.in_b_signed = 0; ifc.in_hi = 0; ifc.in_word = 0; ifc.in_tag = '0;
        ifc.out_ready = 1; ifc.flush = 0;
        ifc8.in_valid = 0; ifc8.in_a = '0; ifc8.in_b = '0; ifc8.in_a_signed = 0;
        ifc8.in_b_signed = 0; ifc8.in_hi = 0; ifc8.in_word = 0; ifc8.in_tag = '0;
        ifc8.out_ready = 1; ifc8.flush = 0;

        // Model pinned to hand-computed values
        check("pin_3x5", mdl_res(64'd3, 64'd5, 0, 0, 0, 0), 64'd15);
        check("pin_ss_lo", mdl_res('1, '1, 1, 1, 0, 0), 64'd1);
        check("pin_ss_hi", mdl_res('1, '1, 1, 1, 1, 0), 64'd0);
        check("pin_uu_hi", mdl_res('1, '1, 0, 0, 1, 0), 64'hFFFF_FFFF_FFFF_FFFE);
        check("pin_su_hi", mdl_res('1, 64'd2, 1, 0, 1, 0), 64'hFFFF_FFFF_FFFF_FFFF);
        check("pin_su_lo", mdl_res('1, 64'd2, 1, 0, 0, 0), 64'hFFFF_FFFF_FFFF_FFFE);
        check("pin_word", mdl_res(64'h7FFF_FFFF, 64'd2, 1, 1, 0, 1), 64'hFFFF_FFFF_FFFF_FFFE);
        check("pin_lat_small", 64'(mdl_lat(64'd3, 0, 0, 32)), 64'd1);
        check("pin_lat_neg", 64'(mdl_lat('1, 1, 0, 32)), 64'd2);
        check("pin_lat8_top", 64'(mdl_lat(64'h0100_0000_0000_0000, 0, 0, 8)), 64'd8);
        check("pin_lat8_ff", 64'(mdl_lat(64'hFF, 0, 0, 8)), 64'd1);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 3*5, single-cycle latency, tag echoed
        issue(64'd3, 64'd5, 0, 0, 0, 0, 5'h1A, 0, w);
        @(negedge clk);
        check("d_3x5_valid", 64'(ifc.out_valid), 64'd1);
        check("d_3x5_res", ifc.out_res, 64'd15);
        check("d_3x5_tag", 64'(ifc.out_tag), 64'h1A);
        wait_idle();

        issue('1, '1, 1, 1, 0, 0, 5'h01, 0, w); wait_idle();
        issue('1, '1, 1, 1, 1, 0, 5'h02, 0, w); wait_idle();
        issue('1, '1, 0, 0, 1, 0, 5'h03, 0, w); wait_idle();
        issue('1, 64'd2, 1, 0, 1, 0, 5'h04, 0, w); wait_idle();
        issue('1, 64'd2, 1, 0, 0, 0, 5'h05, 0, w); wait_idle();
        issue(64'd2, '1, 0, 1, 1, 0, 5'h06, 0, w); wait_idle();
        issue(64'h7FFF_FFFF, 64'd2, 1, 1, 0, 1, 5'h07, 0, w); wait_idle();
        issue(64'hDEAD_8000_0000, 64'h1234_FFFF_FFFF, 1, 0, 1, 1, 5'h08, 0, w); wait_idle();

        // Result held while out_ready low, then retire + accept on one edge
        ifc.out_ready = 1'b0;
        issue(64'h1_0000_0000, 64'd9, 0, 0, 0, 0, 5'h0C, 0, w);
        repeat (2) @(negedge clk);
        repeat (4) begin
            check("hold_valid", 64'(ifc.out_valid), 64'd1);
            check("hold_res", ifc.out_res, 64'h9_0000_0000);
            check("hold_tag", 64'(ifc.out_tag), 64'h0C);
            @(negedge clk);
        end
        ifc.out_ready = 1'b1;
        issue(64'd6, 64'd7, 0, 0, 0, 0, 5'h0D, 0, w);
        check("b2b_wait", 64'(w), 64'd1);
        @(negedge clk);
        check("b2b_res", ifc.out_res, 64'd42);
        wait_idle();

        // Flush one cycle into a two-slice op
        issue(64'h1_0000_0000, 64'd3, 0, 0, 0, 0, 5'h10, 0, w);
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        check("flush_idle", 64'(ifc.busy), 64'd0);
        cycles(3, 0);

        // Reset while holding a finished result
        issue(64'd5, 64'd5, 0, 0, 0, 0, 5'h11, 0, w);
        @(negedge clk);
        ifc.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_kill_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_kill_res", ifc.out_res, 64'd0);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        issue(64'd7, 64'd6, 0, 0, 0, 0, 5'h12, 0, w);
        @(negedge clk);
        check("after_kill_res", ifc.out_res, 64'd42);
        check("after_kill_tag", 64'(ifc.out_tag), 64'h12);
        wait_idle();

        // Random traffic with random backpressure, flush and reset
        for (int i = 0; i < 400; i++) begin
            a = rnd_operand();
            b = rnd_operand();
            issue(a, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  5'($urandom), 1, w);
            cycles($urandom_range(0, 2), 1);
        end
        wait_idle();

        // CHUNK=8 build: latency follows the highest non-zero byte of A
        op8(64'h0100_0000_0000_0000, 64'd3, 0, 0, 0, 0, 5'h15);
        check("c8_top_res", ifc8.out_res, 64'h0300_0000_0000_0000);
        op8(64'hFF, 64'd3, 0, 0, 0, 0, 5'h16);
        check("c8_ff_res", ifc8.out_res, 64'h2FD);
        op8('1, '1, 1, 1, 1, 0, 5'h17);
        op8(64'h8000_0000, 64'd5, 1, 1, 0, 1, 5'h18);
        for (int i = 0; i < 40; i++) begin
            a = rnd_operand();
            b = rnd_operand();
            op8(a, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                5'($urandom));
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning operand/result width; legal values 32, 64.
REQ-002 SHALL have parameter CHUNK, default 32, meaning A-operand bits consumed per cycle; legal values 8, 16, 32, XLEN; XLEN % CHUNK == 0.
REQ-003 SHALL have parameter TAG_W, default 5, meaning width of the sideband tag carried with each operation.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-005 SHALL have input ports: in_valid 1; in_ready (out) 1; in_a XLEN; in_b XLEN; in_a_signed 1; in_b_signed 1; in_hi 1 (select upper half); in_word 1 (32-bit op); in_tag TAG_W.
REQ-006 SHALL have output-side ports: out_valid out 1; out_ready in 1; out_res out XLEN; out_tag out TAG_W; flush in 1 (discard in-flight op); busy out 1 (state != IDLE).

Function
REQ-007 SHALL implement states IDLE, BUSY, DONE; N = XLEN/CHUNK slices.
REQ-008 SHALL accept an op on a rising edge where in_valid && in_ready; in_ready = !flush && (IDLE || (DONE && out_ready)).
REQ-009 On accept SHALL latch operands, flags and tag, clear accumulator, set slice counter to 0, enter BUSY.
REQ-010 Operand extension: A_ext = {in_a_signed & A[MSB], A}, likewise B_ext (XLEN+1 bits); when in_word && XLEN==64, A and B are first replaced by their low 32 bits, sign- or zero-extended per their signed flags.
REQ-011 Each BUSY cycle SHALL add (slice_i(A_ext) * B_ext) << (i*CHUNK) into a 2*XLEN-bit accumulator; slices 0..N-2 are unsigned CHUNK-bit; slice N-1 is signed CHUNK+1-bit, including the extension bit.
REQ-012 Early termination: after slice i < N-1, if A_lock[XLEN-1:(i+1)*CHUNK] == 0, processing SHALL end; otherwise it ends after slice N-1.
REQ-013 Latency SHALL be k cycles from accept edge to out_valid high, k = slices processed (1..N); XLEN=64, CHUNK=32: 1 if A[63:32]==0, else 2.
REQ-014 On the final slice's edge SHALL enter DONE, out_valid=1, out_res/out_tag registered.
REQ-015 Result select: !in_word: out_res = hi ? P[2X-1:X] : P[X-1:0]; in_word: out_res = sext(hi ? P[63:32] : P[31:0]); in_word ignored when XLEN==32.
REQ-016 DONE SHALL hold out_valid, out_res, out_tag stable while out_ready==0.
REQ-017 DONE && out_ready && in_valid (no flush) SHALL retire and accept in the same edge (back-to-back, no bubble); without in_valid, go to IDLE.
REQ-018 flush SHALL, at the next edge, force IDLE, out_valid=0, discarding any BUSY or DONE op; flush wins over simultaneous accept and out handshake.
REQ-019 out_res and out_tag SHALL be don't-care while out_valid==0, but never X after reset.
REQ-020 Unsigned×unsigned, signed×signed and signed×unsigned (either order) SHALL all produce exact 2*XLEN products.

Reset
REQ-021 rst high at an edge SHALL force IDLE, out_valid=0, busy=0, out_res=0, out_tag=0, accumulator=0, counter=0; in_ready=1 the cycle after rst deasserts.
REQ-022 rst mid-BUSY or in DONE SHALL abandon the op with no out_valid pulse; rst has priority over flush and accept.

Verification (XLEN=64, CHUNK=32)
REQ-023 unsigned a=3,b=5,lo -> out_valid 1 cycle after accept, out_res=15; tag 0x1A echoed.
REQ-024 signed a=b=0xFFFF_FFFF_FFFF_FFFF: lo -> 1, hi -> 0, each 2 cycles; unsigned same operands hi -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-025 a signed=-1, b unsigned=2: hi -> 0xFFFF_FFFF_FFFF_FFFF, lo -> 0xFFFF_FFFF_FFFF_FFFE; word signed a=0x7FFF_FFFF,b=2,lo -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-026 out_ready low 3 cycles in DONE -> result/tag held; then out_ready=1 with new in_valid -> retire+accept same edge, second result correct.
REQ-027 flush 1 cycle into a 2-cycle op, and rst asserted in DONE -> no out_valid for the killed op; following op a=7,b=6 -> 42.
REQ-028 CHUNK=8 build: a=0x0100_0000_0000_0000,b=3 -> 8-cycle latency, lo=0x0300_0000_0000_0000; a=0xFF -> 1-cycle latency.
